// File: rtl/exec_pkg.sv
// Shared types and constants for the execute-stage sequencer.
// Op classes, sequencer states and multiplier iteration count.
package exec_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_MUL  = 2'b01,
    CLS_HALT = 2'b10,
    CLS_NOP  = 2'b11
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_HOLD,
    ST_HALTED
  } state_e;

  localparam int MUL_CYCLES = 64;
  localparam int CNT_W      = 7;

endpackage

// File: rtl/mul_iter_unit.sv
// Iterative radix-2 shift-add multiplier, one partial product per cycle.
// product carries the accumulator value after the current cycle's step.
module mul_iter_unit
  import exec_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic         done,
  output logic [127:0] product
);

  logic [63:0]      r_a;
  logic [63:0]      r_b;
  logic [127:0]     r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic [127:0]     w_addend;

  assign w_addend = r_b[r_cnt[5:0]]
                  ? ({64'd0, r_a} << r_cnt[5:0])
                  : '0;
  assign product  = r_acc + w_addend;
  // Last step is the one taken with the counter at 63, so it never wraps.
  assign done     = r_run
                 && (r_cnt == CNT_W'(MUL_CYCLES - 1));

  // Operand latch, accumulator and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (abort) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_a   <= a;
      r_b   <= b;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_acc <= product;
      if (done) r_run <= 1'b0;
      else      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: single-cycle ALU pass-through, iterative
// MUL, result hold with valid/ready handshake, flush and sticky halt.
module exec_sequencer
  import exec_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_class,
  input  logic [63:0] in_alu_result,
  input  logic [63:0] in_op_a,
  input  logic [63:0] in_op_b,
  input  logic [3:0]  in_dest,
  input  logic [3:0]  in_dest_hi,
  input  logic        in_dest_hi_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [63:0] out_result_hi,
  output logic [3:0]  out_dest,
  output logic [3:0]  out_dest_hi,
  output logic        out_dest_hi_valid,
  input  logic        flush,
  output logic        busy,
  output logic        halted
);

  state_e       r_state;
  state_e       w_nxt;
  op_class_e    w_cls;
  logic         w_accept;
  logic         w_dispatch;
  logic         w_start;
  logic         w_abort;
  logic         w_ld_alu;
  logic         w_ld_mul;
  logic         w_ld_dest;
  logic         w_mul_done;
  logic [127:0] w_product;
  logic [63:0]  r_res_lo;
  logic [63:0]  r_res_hi;
  logic [3:0]   r_dest;
  logic [3:0]   r_dest_hi;
  logic         r_dest_hi_v;

  assign w_cls    = op_class_e'(in_class);
  assign in_ready = rst_n && !flush
                 && ((r_state == ST_IDLE)
                  || ((r_state == ST_HOLD) && out_ready));
  assign w_accept = in_valid && in_ready;

  assign out_valid         = (r_state == ST_HOLD);
  assign busy              = (r_state != ST_IDLE);
  assign halted            = (r_state == ST_HALTED);
  assign out_result        = r_res_lo;
  assign out_result_hi     = r_res_hi;
  assign out_dest          = r_dest;
  assign out_dest_hi       = r_dest_hi;
  assign out_dest_hi_valid = r_dest_hi_v;

  mul_iter_unit u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_start),
    .abort   (w_abort),
    .a       (in_op_a),
    .b       (in_op_b),
    .done    (w_mul_done),
    .product (w_product)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  // Next state and load strobes; halt beats flush, flush beats all else.
  always_comb begin
    w_nxt      = r_state;
    w_dispatch = 1'b0;
    w_start    = 1'b0;
    w_abort    = 1'b0;
    w_ld_alu   = 1'b0;
    w_ld_mul   = 1'b0;
    w_ld_dest  = 1'b0;
    if (r_state == ST_HALTED) begin
      w_nxt = ST_HALTED;
    end else if (flush) begin
      w_nxt   = ST_IDLE;
      w_abort = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: w_dispatch = w_accept;
        ST_MUL: begin
          if (w_mul_done) begin
            w_nxt    = ST_HOLD;
            w_ld_mul = 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            w_nxt      = ST_IDLE;
            w_dispatch = w_accept;
          end
        end
        default: w_nxt = ST_IDLE;
      endcase
      if (w_dispatch) begin
        unique case (w_cls)
          CLS_ALU: begin
            w_nxt     = ST_HOLD;
            w_ld_alu  = 1'b1;
            w_ld_dest = 1'b1;
          end
          CLS_MUL: begin
            w_nxt     = ST_MUL;
            w_start   = 1'b1;
            w_ld_dest = 1'b1;
          end
          CLS_HALT: w_nxt = ST_HALTED;
          CLS_NOP:  w_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // Result and destination registers feeding writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_lo    <= '0;
      r_res_hi    <= '0;
      r_dest      <= '0;
      r_dest_hi   <= '0;
      r_dest_hi_v <= 1'b0;
    end else begin
      if (w_ld_alu) begin
        r_res_lo <= in_alu_result;
        r_res_hi <= '0;
      end
      if (w_ld_mul) begin
        r_res_lo <= w_product[63:0];
        r_res_hi <= w_product[127:64];
      end
      if (w_ld_dest) begin
        r_dest      <= in_dest;
        r_dest_hi   <= in_dest_hi;
        r_dest_hi_v <= in_dest_hi_valid;
      end
    end
  end

endmodule
